// File: rtl/if_pc_btb.sv
// if_pc_btb: instruction-fetch PC generator with a direct-mapped branch
// target buffer (BTB).
// Each entry holds a valid bit, a tag, a target and a 2-bit saturating
// direction counter. The lookup for the current pc is combinational. Training
// from EX becomes visible in the cycle after the update edge.
// Optional feature macro: IF_BTB_STATS_EN adds three 32-bit wrapping counters
// (lookups, hits, flushes). Without the macro the stat ports are tied to 0.
module if_pc_btb #(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_hits,
    output logic [31:0]     stat_flushes
);

    localparam int IDXW = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;

    // BTB storage. Only valid and the counters are reset; a stale tag or
    // target is harmless while its valid bit is clear.
    logic            valid_q  [BTB_ENTRIES];
    logic [1:0]      ctr_q    [BTB_ENTRIES];
    logic [TAGW-1:0] tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0] target_q [BTB_ENTRIES];

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Lookup side, addressed by the current fetch pc. pc[1:0] is ignored.
    logic [IDXW-1:0] lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;

    // Training side, addressed by the resolved branch pc.
    logic [IDXW-1:0] upd_idx;
    logic [TAGW-1:0] upd_tag;
    logic            upd_hit;

    // The low two bits of the update pc never select anything.
    logic            unused_upd_lsb;
    assign unused_upd_lsb = ^upd_pc[1:0];

    assign lk_idx  = pc_q[IDXW+1:2];
    assign lk_tag  = pc_q[XLEN-1:IDXW+2];
    assign upd_idx = upd_pc[IDXW+1:2];
    assign upd_tag = upd_pc[XLEN-1:IDXW+2];

    // Combinational prediction from the pre-edge BTB contents (no bypass of
    // a same-cycle update).
    always_comb begin
        lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = lk_hit && ctr_q[lk_idx][1];
        pred_target = pred_taken ? target_q[lk_idx] : '0;
        upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    end

    // Next-PC selection: flush, then stall, then prediction, then
    // sequential fetch. The +4 wraps silently at the top of the address space.
    always_comb begin
        pc_d = pc_q + XLEN'(4);
        if (flush) begin
            pc_d = flush_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    // PC register; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

    // Per-entry valid bit and direction counter. Training ignores stall and
    // flush, but reset wins over it.
    generate
        for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q[gi] <= 1'b0;
                    ctr_q[gi]   <= 2'b01;
                end else if (upd_valid && (upd_idx == IDXW'(gi))) begin
                    if (upd_hit) begin
                        if (upd_taken && (ctr_q[gi] != 2'b11)) begin
                            ctr_q[gi] <= ctr_q[gi] + 2'b01;
                        end else if (!upd_taken && (ctr_q[gi] != 2'b00)) begin
                            ctr_q[gi] <= ctr_q[gi] - 2'b01;
                        end
                    end else if (upd_taken) begin
                        valid_q[gi] <= 1'b1;
                        ctr_q[gi]   <= 2'b10;
                    end
                end
            end
        end
    endgenerate

    // Tag/target array. A taken update always rewrites the target. It also
    // rewrites the tag on a miss, which allocates or replaces the entry.
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_taken) begin
            target_q[upd_idx] <= upd_target;
            if (!upd_hit) begin
                tag_q[upd_idx] <= upd_tag;
            end
        end
    end

`ifdef IF_BTB_STATS_EN
    logic [31:0] lookups_q;
    logic [31:0] hits_q;
    logic [31:0] flushes_q;

    // Usage counters. A lookup is consumed only when the pc advances on the
    // prediction path, meaning the cycle has neither a flush nor a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            lookups_q <= '0;
            hits_q    <= '0;
            flushes_q <= '0;
        end else begin
            if (!flush && !stall) begin
                lookups_q <= lookups_q + 32'd1;
                if (pred_taken) begin
                    hits_q <= hits_q + 32'd1;
                end
            end
            if (flush) begin
                flushes_q <= flushes_q + 32'd1;
            end
        end
    end

    assign stat_lookups = lookups_q;
    assign stat_hits    = hits_q;
    assign stat_flushes = flushes_q;
`else
    assign stat_lookups = '0;
    assign stat_hits    = '0;
    assign stat_flushes = '0;
`endif

endmodule

// File: tb/tb_if_pc_btb.sv
// Directed testbench for if_pc_btb (XLEN=32, 16 entries, RESET_PC=0x100).
// Expected statistics depend on whether IF_BTB_STATS_EN is defined.
module tb_if_pc_btb;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] stat_lookups;
    logic [31:0] stat_hits;
    logic [31:0] stat_flushes;

    int tests_run = 0;
    int tests_failed = 0;

    if_pc_btb #(
        .XLEN        (32),
        .BTB_ENTRIES (16),
        .RESET_PC    (32'h0000_0100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .pc           (pc),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .stat_lookups (stat_lookups),
        .stat_hits    (stat_hits),
        .stat_flushes (stat_flushes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled and inputs changed 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle();
        rst = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    endtask

    task automatic set_upd(input logic [31:0] p, input logic t, input logic [31:0] tgt);
        upd_valid = 1'b1; upd_pc = p; upd_taken = t; upd_target = tgt;
    endtask

    initial begin
        logic [31:0] exp_lk;
        logic [31:0] exp_hit;
        logic [31:0] exp_fl;

        idle();
        rst = 1'b1;

        // 1. Reset and sequential fetch
        step(); step();
        chk("rst_pc", pc, 32'h100);
        chk("rst_pred", {31'd0, pred_taken}, 32'd0);
        chk("rst_lookups", stat_lookups, 32'd0);
        rst = 1'b0;
        step(); chk("seq_104", pc, 32'h104);
        step(); chk("seq_108", pc, 32'h108);
        step(); chk("seq_10c", pc, 32'h10C);

        // 2. Allocate 0x108 -> 0x200 while redirecting to 0x108
        set_upd(32'h108, 1'b1, 32'h200);
        flush = 1'b1; flush_pc = 32'h108;
        step(); idle();
        chk("alloc_pc", pc, 32'h108);
        chk("alloc_pred", {31'd0, pred_taken}, 32'd1);
        chk("alloc_tgt", pred_target, 32'h200);
        step(); chk("follow_200", pc, 32'h200);
        chk("miss_tgt_zero", pred_target, 32'd0);

        // 3. Counter walks down and saturates at 00
        set_upd(32'h108, 1'b0, 32'h0);
        flush = 1'b1; flush_pc = 32'h108;
        step(); idle();                               // ctr 10 -> 01
        chk("ctr01_pred", {31'd0, pred_taken}, 32'd0);
        chk("ctr01_tgt", pred_target, 32'd0);
        set_upd(32'h108, 1'b0, 32'h0);
        step(); idle();                               // ctr 01 -> 00
        chk("ctr00_pc", pc, 32'h10C);
        set_upd(32'h108, 1'b0, 32'h0);
        step(); idle();                               // held at 00
        chk("hold_pc", pc, 32'h110);
        set_upd(32'h108, 1'b1, 32'h200);
        flush = 1'b1; flush_pc = 32'h108;
        step(); idle();                               // 00 -> 01
        chk("no_underflow", {31'd0, pred_taken}, 32'd0);
        set_upd(32'h108, 1'b1, 32'h240);
        step(); idle();                               // lookup saw 01; now 10
        chk("no_bypass_pc", pc, 32'h10C);
        flush = 1'b1; flush_pc = 32'h108;
        step(); idle();
        chk("retrain_pred", {31'd0, pred_taken}, 32'd1);
        chk("retrain_tgt", pred_target, 32'h240);
        step(); chk("follow_240", pc, 32'h240);

        // 4. Flush beats stall, then stall holds
        stall = 1'b1; flush = 1'b1; flush_pc = 32'h300;
        step(); chk("flush_over_stall", pc, 32'h300);
        flush = 1'b0;
        step(); chk("stall_1", pc, 32'h300);
        step(); chk("stall_2", pc, 32'h300);
        step(); chk("stall_3", pc, 32'h300);
        idle();

        // 5. Aliasing replacement and address wrap
        set_upd(32'h148, 1'b1, 32'h400);
        flush = 1'b1; flush_pc = 32'h108;
        step(); idle();
        chk("alias_miss", {31'd0, pred_taken}, 32'd0);
        step(); chk("alias_seq", pc, 32'h10C);
        flush = 1'b1; flush_pc = 32'h148;
        step(); idle();
        chk("alias_new_hit", pred_target, 32'h400);
        flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
        step(); idle();
        chk("top_pred", {31'd0, pred_taken}, 32'd0);
        step(); chk("wrap_pc", pc, 32'h0);

        // 6. Mid-stream reset beats flush, stall and training; then statistics
        rst = 1'b1; stall = 1'b1; flush = 1'b1; flush_pc = 32'h700;
        set_upd(32'h100, 1'b1, 32'h500);
        step(); idle();
        chk("rst_win_pc", pc, 32'h100);
        chk("rst_win_pred", {31'd0, pred_taken}, 32'd0);
        chk("rst_clr_flushes", stat_flushes, 32'd0);
        // Train 0x108 -> 0x100 while stalled, so the cycle does not count as a lookup.
        stall = 1'b1;
        set_upd(32'h108, 1'b1, 32'h100);
        step(); idle();
        for (int i = 0; i < 8; i++) step();           // 100 104 108* 100 104 108* 100 104
        chk("loop_pc", pc, 32'h108);
        flush = 1'b1; flush_pc = 32'h110;
        step(); idle();
        step(); step();                               // 110, 114
        chk("stats_pc", pc, 32'h118);
`ifdef IF_BTB_STATS_EN
        exp_lk = 32'd10; exp_hit = 32'd2; exp_fl = 32'd1;
`else
        exp_lk = 32'd0; exp_hit = 32'd0; exp_fl = 32'd0;
`endif
        chk("stat_lookups", stat_lookups, exp_lk);
        chk("stat_hits", stat_hits, exp_hit);
        chk("stat_flushes", stat_flushes, exp_fl);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
